// File: rtl/uart_pkg.sv
// Shared constants, divider helper and receive-FSM state encoding for the UART slice.
package uart_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 24_000_000;
  localparam int unsigned BAUD_DEFAULT   = 57_600;
  localparam int unsigned OVERSAMPLE     = 16;
  localparam int unsigned STATE_W        = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

  // Clocks per oversampling tick (integer division, truncating).
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, realignable via restart.
module uart_rx_tick #(
  parameter int unsigned DIV = 26
) (
  input  logic clki,
  input  logic rstn,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Restart wins over the terminal count so the new phase starts cleanly at 0.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + CNT_W'(1);
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clki) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampled centre-sampling FSM and
// a valid/ready holding register with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned BAUD   = BAUD_DEFAULT
) (
  input  logic       clki,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       dvalid,
  input  logic       dready,
  output logic       ferr,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV    = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
  localparam logic [TCNT_W-1:0] T_HALF = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(OVERSAMPLE - 1);

  logic [1:0]        sync_q;
  logic              rx_s;
  state_t            state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              ferr_q, ferr_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic              restart;
  logic              tick;
  logic              load;

  assign rx_s = sync_q[1];

  uart_rx_tick #(
    .DIV (DIV)
  ) u_tick (
    .clki    (clki),
    .rstn    (rstn),
    .restart (restart),
    .tick    (tick)
  );

  // Next-state, datapath and holding-register logic.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    restart   = 1'b0;
    load      = 1'b0;
    ferr_d    = 1'b0;
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          tcnt_d  = '0;
          restart = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tcnt_q == T_HALF) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            tcnt_d  = '0;
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = ST_STOP;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_d = '0;
            if (rx_s) begin
              load    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A load coinciding with an accept replaces the byte without flagging overrun.
    if (load) begin
      dout_d    = shreg_q;
      dvalid_d  = 1'b1;
      overrun_d = dvalid_q && !dready;
    end else if (dvalid_q && dready) begin
      dvalid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clki) begin
    if (!rstn) begin
      sync_q    <= 2'b11;
      state_q   <= ST_IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign dout    = dout_q;
  assign dvalid  = dvalid_q;
  assign ferr    = ferr_q;
  assign overrun = overrun_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are generated bit-by-bit at a chosen bit period,
// expected bytes/flags are queued at issue time and a monitor checks each DUT event.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLKS = 417;

  logic       clki = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       dready = 1'b0;
  logic [7:0] dout;
  logic       dvalid;
  logic       ferr;
  logic       overrun;
  logic       busy;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    bit         ovr;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         pending = 1'b0;
  bit         prev_dv = 1'b0;
  bit         prev_acc = 1'b0;
  int         tol_clks[2] = '{405, 430};
  logic [7:0] tol_pats[3] = '{8'h00, 8'hFF, 8'h5A};

  uart_rx dut (
    .clki    (clki),
    .rstn    (rstn),
    .rx      (rx),
    .dout    (dout),
    .dvalid  (dvalid),
    .dready  (dready),
    .ferr    (ferr),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clki = ~clki;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: a good frame yields its byte; overrun iff a byte is still unconsumed.
  task automatic expect_byte(input logic [7:0] d);
    exp_t e;
    e.is_ferr = 1'b0;
    e.data    = d;
    e.ovr     = pending && !dready;
    exp_q.push_back(e);
    pending = !dready;
  endtask

  task automatic expect_ferr();
    exp_t e;
    e.is_ferr = 1'b1;
    e.data    = 8'h00;
    e.ovr     = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int bclk, input logic stop_v);
    drive(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive(d[i], bclk);
    drive(stop_v, bclk);
  endtask

  task automatic send_ok(input logic [7:0] d, input int bclk);
    expect_byte(d);
    send_frame(d, bclk, 1'b1);
    drive(1'b1, 20);
  endtask

  // Monitor: a load shows as dvalid rising, an overrun, or dvalid held across an accept.
  always @(negedge clki) begin
    bit   load;
    exp_t e;
    load = (dvalid && !prev_dv) || overrun || (dvalid && prev_acc);
    if (ferr || load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {ferr, load}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_is_ferr", ferr, e.is_ferr);
        if (!e.is_ferr) begin
          chk("dout", dout, e.data);
          chk("overrun", overrun, e.ovr);
        end
      end
    end
    prev_dv  = dvalid;
    prev_acc = dvalid && dready;
  end

  initial begin
    repeat (100000) @(posedge clki);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw_busy;

    repeat (4) @(posedge clki);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rstn   = 1'b1;
    dready = 1'b1;
    drive(1'b1, 50);

    send_ok(8'h55, BIT_CLKS);
    chk("idle_after_55_busy", busy, 0);
    chk("idle_after_55_dvalid", dvalid, 0);

    // Short low glitch must be rejected at the start-bit centre.
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clki);
      #1;
      if (busy) saw_busy = 1'b1;
    end
    drive(1'b1, 400);
    chk("glitch_saw_busy", saw_busy, 1);
    chk("glitch_busy_after", busy, 0);
    chk("glitch_dvalid", dvalid, 0);

    expect_ferr();
    send_frame(8'hA3, BIT_CLKS, 1'b0);
    drive(1'b0, 3 * BIT_CLKS);
    chk("ferr_dvalid", dvalid, 0);
    drive(1'b1, 50);
    send_ok(8'h3C, BIT_CLKS);

    dready = 1'b0;
    expect_byte(8'h12);
    send_frame(8'h12, BIT_CLKS, 1'b1);
    expect_byte(8'h34);
    send_frame(8'h34, BIT_CLKS, 1'b1);
    drive(1'b1, 20);
    chk("ovr_dout", dout, 8'h34);
    chk("ovr_dvalid", dvalid, 1);
    dready = 1'b1;
    @(posedge clki);
    #1;
    dready  = 1'b0;
    pending = 1'b0;
    chk("accept_clears_dvalid", dvalid, 0);

    // Park a byte, then reset in the middle of bit 4 of 0xFF.
    send_ok(8'h66, BIT_CLKS);
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(1'b1, BIT_CLKS);
    drive(1'b1, BIT_CLKS / 2);
    rstn = 1'b0;
    @(posedge clki);
    #1;
    rstn    = 1'b1;
    pending = 1'b0;
    @(negedge clki);
    chk("midrst_dout", dout, 0);
    chk("midrst_dvalid", dvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ferr", ferr, 0);
    chk("midrst_overrun", overrun, 0);
    dready = 1'b1;
    drive(1'b1, 3 * BIT_CLKS);
    send_ok(8'h81, BIT_CLKS);

    foreach (tol_clks[b]) begin
      foreach (tol_pats[p]) send_ok(tol_pats[p], tol_clks[b]);
    end

    repeat (3) send_ok(8'($urandom_range(0, 255)), 405 + int'($urandom_range(0, 25)));

    drive(1'b1, 50);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
